uart_cmd_assembler: RTL and testbench



---
 rtl/uart_cmd_assembler.sv | 127 ++++++++++++
 tb/tb_uart_cmd_assembler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: builds 16-bit commands from UART byte pairs, filters by ID, stages angles for shoot, and answers with ACK/NAK.
module uart_cmd_assembler #(
  parameter logic [3:0]  MODULE_ID      = 4'h1,
  parameter int unsigned TIMEOUT_CYCLES = 24000,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5,
  parameter logic [7:0]  NAK_BYTE       = 8'h5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        rx_parity_error,
  input  logic        shoot,
  input  logic        tx_busy,
  output logic        start_tx,
  output logic [7:0]  data_to_tx,
  output logic [11:0] angle,
  output logic        staged_valid,
  output logic        msg_valid,
  output logic        frame_error,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {IDLE, WAIT_LO, CHECK} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [7:0] hi_q, hi_d, lo_q, lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] staged_q, staged_d, angle_q, angle_d;
  logic staged_valid_q, staged_valid_d, msg_valid_q, msg_valid_d;
  logic frame_error_q, frame_error_d, start_tx_q, start_tx_d;
  logic ack_pending_q, ack_pending_d;
  logic [7:0] data_to_tx_q, data_to_tx_d, ack_data_q, ack_data_d;
  logic [7:0] err_count_q, err_count_d;
  logic [2:0] sync_q, sync_d;
  logic rise, accept, reject, queue;
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    cnt_d = cnt_q;
    accept = 1'b0;
    reject = 1'b0;
    case (state_q)
      IDLE: if (rx_done) begin
        reject = rx_parity_error;
        if (!rx_parity_error) begin
          hi_d = rx_data;
          cnt_d = '0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        cnt_d = cnt_q + 16'd1;
        if (rx_done) begin
          reject = rx_parity_error;
          lo_d = rx_parity_error ? lo_q : rx_data;
          state_d = rx_parity_error ? IDLE : CHECK;
        end else if (cnt_q == TO_LAST) begin
          reject = 1'b1;
          state_d = IDLE;
        end
      end
      CHECK: begin
        // ID mismatch is dropped silently so other modules on the bus can answer
        accept = (hi_q[7:4] == MODULE_ID) || (hi_q[7:4] == 4'hF);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    sync_d = {sync_q[1:0], shoot};
    rise = sync_q[1] & ~sync_q[2];
    queue = accept | reject;
    msg_valid_d = accept;
    frame_error_d = reject;
    err_count_d = (reject && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    angle_d = (rise && staged_valid_q) ? staged_q : angle_q;
    staged_d = accept ? {hi_q[3:0], lo_q} : staged_q;
    staged_valid_d = accept | (staged_valid_q & ~rise);
    // a fresh queue event can launch in the same cycle; newest byte wins
    ack_data_d = queue ? (accept ? ACK_BYTE : NAK_BYTE) : ack_data_q;
    start_tx_d = (ack_pending_q | queue) & ~tx_busy & ~start_tx_q;
    ack_pending_d = (ack_pending_q | queue) & ~start_tx_d;
    data_to_tx_d = start_tx_d ? ack_data_d : data_to_tx_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      staged_q <= '0;
      angle_q <= '0;
      staged_valid_q <= 1'b0;
      msg_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      start_tx_q <= 1'b0;
      ack_pending_q <= 1'b0;
      data_to_tx_q <= '0;
      ack_data_q <= '0;
      err_count_q <= '0;
      sync_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      cnt_q <= cnt_d;
      staged_q <= staged_d;
      angle_q <= angle_d;
      staged_valid_q <= staged_valid_d;
      msg_valid_q <= msg_valid_d;
      frame_error_q <= frame_error_d;
      start_tx_q <= start_tx_d;
      ack_pending_q <= ack_pending_d;
      data_to_tx_q <= data_to_tx_d;
      ack_data_q <= ack_data_d;
      err_count_q <= err_count_d;
      sync_q <= sync_d;
    end
  end
  assign start_tx = start_tx_q;
  assign data_to_tx = data_to_tx_q;
  assign angle = angle_q;
  assign staged_valid = staged_valid_q;
  assign msg_valid = msg_valid_q;
  assign frame_error = frame_error_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb_uart_cmd_assembler: directed checks of framing, ID filter, ACK/NAK, timeout, shoot staging and reset.
module tb_uart_cmd_assembler;
  logic clk = 1'b0, reset = 1'b1, rx_done = 1'b0, rx_parity_error = 1'b0, shoot = 1'b0, tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic start_tx, staged_valid, msg_valid, frame_error;
  logic [7:0] data_to_tx, err_count;
  logic [11:0] angle;
  int checks = 0, errors = 0;
  int n_msg = 0, n_ferr = 0, n_tx = 0;
  int m0, f0, t0;
  logic [7:0] last_tx = 8'h00;
  uart_cmd_assembler #(.MODULE_ID(4'h1), .TIMEOUT_CYCLES(100), .ACK_BYTE(8'hA5), .NAK_BYTE(8'h5A)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .rx_parity_error(rx_parity_error),
    .shoot(shoot), .tx_busy(tx_busy), .start_tx(start_tx), .data_to_tx(data_to_tx), .angle(angle),
    .staged_valid(staged_valid), .msg_valid(msg_valid), .frame_error(frame_error), .err_count(err_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (msg_valid) n_msg++;
    if (frame_error) n_ferr++;
    if (start_tx) begin
      n_tx++;
      last_tx = data_to_tx;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic p);
    @(posedge clk);
    #1;
    rx_data = d;
    rx_parity_error = p;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_parity_error = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(3);
    chk("rst_angle", angle, 0);
    chk("rst_staged_valid", staged_valid, 0);
    chk("rst_start_tx", start_tx, 0);
    chk("rst_data_to_tx", data_to_tx, 0);
    chk("rst_msg_valid", msg_valid, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;
    tick(2);
    m0 = n_msg; t0 = n_tx;
    send(8'h12, 0);
    send(8'h34, 0);
    tick(1);
    chk("acc_msg_valid", msg_valid, 1);
    chk("acc_staged_valid", staged_valid, 1);
    chk("acc_start_tx", start_tx, 1);
    chk("acc_ack_byte", data_to_tx, 8'hA5);
    tick(1);
    chk("acc_start_one_cycle", start_tx, 0);
    tick(3);
    chk("acc_msg_pulses", n_msg - m0, 1);
    chk("acc_tx_count", n_tx - t0, 1);
    chk("acc_angle_before_shoot", angle, 0);
    shoot = 1'b1;
    tick(2);
    chk("shoot_angle_at_2", angle, 0);
    tick(1);
    chk("shoot_angle_at_3", angle, 12'h234);
    chk("shoot_staged_cleared", staged_valid, 0);
    shoot = 1'b0;
    tick(3);
    t0 = n_tx;
    send(8'h56, 0);
    send(8'h78, 1);
    chk("par_frame_error", frame_error, 1);
    chk("par_err_count", err_count, 1);
    chk("par_start_tx", start_tx, 1);
    chk("par_nak_byte", data_to_tx, 8'h5A);
    tick(1);
    chk("par_frame_error_pulse", frame_error, 0);
    chk("par_angle_kept", angle, 12'h234);
    chk("par_tx_count", n_tx - t0, 1);
    send(8'h13, 0);
    tick(99);
    chk("to_not_yet", frame_error, 0);
    tick(1);
    chk("to_frame_error", frame_error, 1);
    chk("to_err_count", err_count, 2);
    chk("to_start_tx", start_tx, 1);
    chk("to_nak_byte", data_to_tx, 8'h5A);
    m0 = n_msg;
    send(8'hF0, 0);
    send(8'h07, 0);
    tick(1);
    chk("bc_msg_valid", msg_valid, 1);
    chk("bc_staged_valid", staged_valid, 1);
    tick(2);
    chk("bc_msg_pulses", n_msg - m0, 1);
    shoot = 1'b1;
    tick(3);
    chk("bc_angle", angle, 12'h007);
    shoot = 1'b0;
    tick(3);
    m0 = n_msg; f0 = n_ferr; t0 = n_tx;
    send(8'h2A, 0);
    send(8'hBC, 0);
    tick(5);
    chk("id_no_msg", n_msg - m0, 0);
    chk("id_no_ferr", n_ferr - f0, 0);
    chk("id_no_tx", n_tx - t0, 0);
    chk("id_err_count", err_count, 2);
    chk("id_not_staged", staged_valid, 0);
    tx_busy = 1'b1;
    m0 = n_msg; t0 = n_tx;
    send(8'h11, 0); send(8'h11, 0);
    send(8'h12, 0); send(8'h22, 0);
    tick(4);
    chk("bp_held", n_tx - t0, 0);
    chk("bp_two_msgs", n_msg - m0, 2);
    tx_busy = 1'b0;
    tick(5);
    chk("bp_one_tx", n_tx - t0, 1);
    chk("bp_ack_byte", last_tx, 8'hA5);
    tx_busy = 1'b1;
    t0 = n_tx;
    send(8'h13, 0); send(8'h33, 0);
    send(8'h14, 0); send(8'h44, 1);
    tick(3);
    tx_busy = 1'b0;
    tick(5);
    chk("ovr_one_tx", n_tx - t0, 1);
    chk("ovr_latest_nak", last_tx, 8'h5A);
    chk("ovr_err_count", err_count, 3);
    send(8'h1A, 0);
    shoot = 1'b1;
    send(8'hBC, 0);
    tick(1);
    chk("coin_angle_old", angle, 12'h333);
    chk("coin_still_staged", staged_valid, 1);
    chk("coin_msg_valid", msg_valid, 1);
    shoot = 1'b0;
    tick(4);
    shoot = 1'b1;
    tick(3);
    chk("coin_new_angle", angle, 12'hABC);
    chk("coin_staged_cleared", staged_valid, 0);
    shoot = 1'b0;
    for (int i = 0; i < 251; i++) send(8'h00, 1);
    chk("sat_254", err_count, 254);
    send(8'h00, 1);
    chk("sat_255", err_count, 255);
    for (int i = 0; i < 4; i++) send(8'h00, 1);
    chk("sat_hold", err_count, 255);
    tick(3);
    tx_busy = 1'b1;
    send(8'h10, 0); send(8'h01, 0);
    send(8'h1F, 0);
    reset = 1'b1;
    #1;
    chk("rwl_angle", angle, 0);
    chk("rwl_staged_valid", staged_valid, 0);
    chk("rwl_err_count", err_count, 0);
    chk("rwl_start_tx", start_tx, 0);
    chk("rwl_data_to_tx", data_to_tx, 0);
    chk("rwl_msg_valid", msg_valid, 0);
    chk("rwl_frame_error", frame_error, 0);
    tick(2);
    reset = 1'b0;
    tx_busy = 1'b0;
    tick(1);
    m0 = n_msg; t0 = n_tx;
    send(8'h22, 0);
    tick(4);
    chk("rwl_pending_dropped", n_tx - t0, 0);
    chk("rwl_partial_dropped", n_msg - m0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
